// File: rtl/scan_mux_if.sv
// Bus interface for scan_mux: control, select, packed channel data and the
// registered result. Clock and reset stay as plain ports on the module.
interface scan_mux_if #(
   parameter int N_CH    = 8,
   parameter int SEL_W   = 3,
   parameter int DW      = 1,
   parameter int DWELL_W = 4
);
   logic                 en;
   logic                 mode;
   logic [SEL_W-1:0]     s;
   logic [N_CH*DW-1:0]   i;
   logic [DWELL_W-1:0]   dwell;
   logic [DW-1:0]        y;
   logic [SEL_W-1:0]     ch;
   logic                 valid;
   logic                 wrap;
   logic                 range_err;

   modport master (
      output en, mode, s, i, dwell,
      input  y, ch, valid, wrap, range_err
   );

   modport slave (
      input  en, mode, s, i, dwell,
      output y, ch, valid, wrap, range_err
   );
endinterface

// File: rtl/scan_mux.sv
// Registered N-to-1 multiplexer with manual select and an auto-scan mode.
// Auto-scan steps through every channel, holding each for dwell+1 enabled
// cycles, and flags the last sample of the final channel with wrap.
module scan_mux #(
   parameter int N_CH    = 8,
   parameter int SEL_W   = 3,
   parameter int DW      = 1,
   parameter int DWELL_W = 4
) (
   input  logic      clk,
   input  logic      rst_n,
   scan_mux_if.slave bus
);

   typedef enum logic {
      MAN  = 1'b0,
      SCAN = 1'b1
   } state_e;

   // One extra bit so N_CH == 2**SEL_W is representable.
   localparam logic [SEL_W:0]   CH_LIMIT = (SEL_W+1)'(N_CH);
   localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(N_CH - 1);

   state_e               state_q, state_d;
   logic [SEL_W-1:0]     p_q, p_d;
   logic [DWELL_W-1:0]   dc_q, dc_d;
   logic [DW-1:0]        y_q, y_d;
   logic [SEL_W-1:0]     ch_q, ch_d;
   logic                 valid_q, valid_d;
   logic                 wrap_q, wrap_d;
   logic                 range_err_q, range_err_d;

   // Scan pointer and dwell count actually used this edge (zeroed on entry).
   logic [SEL_W-1:0]     p_eff;
   logic [DWELL_W-1:0]   dc_eff;

   // Out-of-range indices return zero rather than aliasing another channel.
   function automatic logic [DW-1:0] pick(input logic [N_CH*DW-1:0] vec,
                                         input logic [SEL_W-1:0]   idx);
      logic [DW-1:0] r;
      r = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (idx == SEL_W'(k)) r = vec[k*DW +: DW];
      end
      return r;
   endfunction

   // Next-state and output decode for both modes and the clock enable.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it
      // unassigned; otherwise synthesis infers a latch.
      state_d     = state_q;
      p_d         = p_q;
      dc_d        = dc_q;
      y_d         = y_q;
      ch_d        = ch_q;
      valid_d     = 1'b0;
      wrap_d      = 1'b0;
      range_err_d = range_err_q;
      p_eff       = p_q;
      dc_eff      = dc_q;

      if (bus.en) begin
         state_d = bus.mode ? SCAN : MAN;
         if (state_d == MAN) begin
            ch_d = bus.s;
            if ({1'b0, bus.s} < CH_LIMIT) begin
               y_d         = pick(bus.i, bus.s);
               valid_d     = 1'b1;
               range_err_d = 1'b0;
            end else begin
               y_d         = '0;
               range_err_d = 1'b1;
            end
         end else begin
            // Every entry into scan starts at channel 0 with a fresh dwell.
            if (state_q == MAN) begin
               p_eff  = '0;
               dc_eff = '0;
            end
            y_d         = pick(bus.i, p_eff);
            ch_d        = p_eff;
            valid_d     = 1'b1;
            range_err_d = 1'b0;
            // >= so that lowering dwell mid-dwell advances immediately.
            if (dc_eff >= bus.dwell) begin
               dc_d   = '0;
               p_d    = (p_eff == LAST_CH) ? '0 : p_eff + SEL_W'(1);
               wrap_d = (p_eff == LAST_CH);
            end else begin
               dc_d   = dc_eff + DWELL_W'(1);
               p_d    = p_eff;
            end
         end
      end
   end

   // State and output registers; async clear to the idle manual state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= MAN;
         p_q         <= '0;
         dc_q        <= '0;
         y_q         <= '0;
         ch_q        <= '0;
         valid_q     <= 1'b0;
         wrap_q      <= 1'b0;
         range_err_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values, independent of statement order.
         state_q     <= state_d;
         p_q         <= p_d;
         dc_q        <= dc_d;
         y_q         <= y_d;
         ch_q        <= ch_d;
         valid_q     <= valid_d;
         wrap_q      <= wrap_d;
         range_err_q <= range_err_d;
      end
   end

   assign bus.y         = y_q;
   assign bus.ch        = ch_q;
   assign bus.valid     = valid_q;
   assign bus.wrap      = wrap_q;
   assign bus.range_err = range_err_q;

endmodule

// File: tb/tb_scan_mux.sv
// Self-checking bench for scan_mux: an 8-channel and a 6-channel instance,
// 4-bit data where channel k carries the value k.
module tb_scan_mux;

   logic clk;
   logic rst_n;

   scan_mux_if #(.N_CH(8), .SEL_W(3), .DW(4), .DWELL_W(4)) if8 ();
   scan_mux_if #(.N_CH(6), .SEL_W(3), .DW(4), .DWELL_W(4)) if6 ();

   scan_mux #(.N_CH(8), .SEL_W(3), .DW(4), .DWELL_W(4)) u_dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if8.slave)
   );

   scan_mux #(.N_CH(6), .SEL_W(3), .DW(4), .DWELL_W(4)) u_dut6 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if6.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       mode;
      logic       en;
      logic [2:0] s;
      logic [3:0] dwell;
      logic [3:0] y;
      logic [2:0] ch;
      logic       valid;
      logic       wrap;
      logic       rerr;
   } vec_t;

   vec_t man_tbl[8];
   int   n_pass  = 0;
   int   n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic check8(input string tag, input logic [3:0] y, input logic [2:0] ch,
                         input logic valid, input logic wrap, input logic rerr);
      check({tag, ".y"},         32'(if8.y),         32'(y));
      check({tag, ".ch"},        32'(if8.ch),        32'(ch));
      check({tag, ".valid"},     32'(if8.valid),     32'(valid));
      check({tag, ".wrap"},      32'(if8.wrap),      32'(wrap));
      check({tag, ".range_err"}, 32'(if8.range_err), 32'(rerr));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      man_tbl[0] = '{1'b0, 1'b1, 3'd0, 4'd0, 4'h0, 3'd0, 1'b1, 1'b0, 1'b0};
      man_tbl[1] = '{1'b0, 1'b1, 3'd1, 4'd0, 4'h1, 3'd1, 1'b1, 1'b0, 1'b0};
      man_tbl[2] = '{1'b0, 1'b1, 3'd2, 4'd0, 4'h2, 3'd2, 1'b1, 1'b0, 1'b0};
      man_tbl[3] = '{1'b0, 1'b1, 3'd3, 4'd0, 4'h3, 3'd3, 1'b1, 1'b0, 1'b0};
      man_tbl[4] = '{1'b0, 1'b1, 3'd4, 4'd0, 4'h4, 3'd4, 1'b1, 1'b0, 1'b0};
      man_tbl[5] = '{1'b0, 1'b1, 3'd5, 4'd0, 4'h5, 3'd5, 1'b1, 1'b0, 1'b0};
      man_tbl[6] = '{1'b0, 1'b1, 3'd6, 4'd0, 4'h6, 3'd6, 1'b1, 1'b0, 1'b0};
      man_tbl[7] = '{1'b0, 1'b1, 3'd7, 4'd0, 4'h7, 3'd7, 1'b1, 1'b0, 1'b0};

      rst_n     = 1'b0;
      if8.en    = 1'b0; if8.mode = 1'b0; if8.s = 3'd0; if8.dwell = 4'd0;
      if8.i     = 32'h7654_3210;
      if6.en    = 1'b0; if6.mode = 1'b0; if6.s = 3'd0; if6.dwell = 4'd0;
      if6.i     = 24'h54_3210;

      // Reset state.
      #12;
      check8("reset8", 4'h0, 3'd0, 1'b0, 1'b0, 1'b0);
      check("reset6.valid", 32'(if6.valid), 32'd0);
      check("reset6.range_err", 32'(if6.range_err), 32'd0);
      rst_n  = 1'b1;
      if8.en = 1'b1;
      if6.en = 1'b1;

      // Manual select of every channel, table driven.
      for (int v = 0; v < 8; v++) begin
         if8.mode  = man_tbl[v].mode;
         if8.en    = man_tbl[v].en;
         if8.s     = man_tbl[v].s;
         if8.dwell = man_tbl[v].dwell;
         tick();
         check8($sformatf("man_s%0d", v), man_tbl[v].y, man_tbl[v].ch,
                man_tbl[v].valid, man_tbl[v].wrap, man_tbl[v].rerr);
      end

      // Out-of-range select on the 6-channel instance, then recovery.
      if6.s = 3'd7;
      tick();
      check("rng.y",         32'(if6.y),         32'h0);
      check("rng.ch",        32'(if6.ch),        32'd7);
      check("rng.valid",     32'(if6.valid),     32'd0);
      check("rng.range_err", 32'(if6.range_err), 32'd1);
      if6.s = 3'd2;
      tick();
      check("rec.y",         32'(if6.y),         32'h2);
      check("rec.valid",     32'(if6.valid),     32'd1);
      check("rec.range_err", 32'(if6.range_err), 32'd0);

      // 6-channel scan with dwell=0: wrap on channel 5 only.
      if6.mode  = 1'b1;
      if6.dwell = 4'd0;
      for (int n = 0; n < 7; n++) begin
         tick();
         check($sformatf("scan6_%0d.ch", n),   32'(if6.ch),   32'(n % 6));
         check($sformatf("scan6_%0d.y", n),    32'(if6.y),    32'(n % 6));
         check($sformatf("scan6_%0d.wrap", n), 32'(if6.wrap), 32'((n % 6) == 5));
      end

      // Auto-scan with dwell=2: 24-cycle period, wrap on the 3rd cycle of ch 7.
      if8.mode  = 1'b1;
      if8.dwell = 4'd2;
      for (int n = 0; n < 25; n++) begin
         tick();
         check8($sformatf("scan8_%0d", n), 4'((n / 3) % 8), 3'((n / 3) % 8),
                1'b1, (n % 24) == 23, 1'b0);
      end

      // dwell=0 scan, freeze with en=0 at ch 3, then resume at ch 4.
      if8.mode = 1'b0;
      if8.s    = 3'd0;
      tick();
      if8.mode  = 1'b1;
      if8.dwell = 4'd0;
      for (int k = 0; k < 4; k++) begin
         tick();
         check8($sformatf("fast_%0d", k), 4'(k), 3'(k), 1'b1, 1'b0, 1'b0);
      end
      if8.en = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         check8($sformatf("hold_%0d", k), 4'h3, 3'd3, 1'b0, 1'b0, 1'b0);
      end
      if8.en = 1'b1;
      tick();
      check8("resume", 4'h4, 3'd4, 1'b1, 1'b0, 1'b0);

      // Mode 1->0->1 at ch 5: re-entry restarts at ch 0 with a fresh dwell.
      tick();
      check8("pre_switch", 4'h5, 3'd5, 1'b1, 1'b0, 1'b0);
      if8.mode = 1'b0;
      if8.s    = 3'd1;
      tick();
      check8("switch_man", 4'h1, 3'd1, 1'b1, 1'b0, 1'b0);
      if8.mode  = 1'b1;
      if8.dwell = 4'd2;
      for (int k = 0; k < 4; k++) begin
         tick();
         check8($sformatf("reentry_%0d", k), 4'(k / 3), 3'(k / 3), 1'b1, 1'b0, 1'b0);
      end

      // Asynchronous reset between edges mid-scan.
      #2;
      rst_n = 1'b0;
      #1;
      check8("async_rst", 4'h0, 3'd0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         check8($sformatf("post_rst_%0d", k), 4'(k / 3), 3'(k / 3), 1'b1, 1'b0, 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/scan_mux.md
Name: scan_mux

Overview:
Parametrised, registered N-to-1 multiplexer. It is the successor to the fixed 8:1 combinational mux.
- Adds configurable channel count and data width.
- Registers the output with a valid flag.
- Adds an auto-scan mode that steps through all channels with a programmable dwell time and pulses a wrap flag at the end of each full scan.
- Used wherever several sensor or data lanes are time-shared onto one output path.

Parameters:
N_CH, 8, number of input channels (2..2^SEL_W).
SEL_W, 3, select and channel-index width; requires 2^SEL_W >= N_CH.
DW, 1, data width per channel.
DWELL_W, 4, width of the dwell-count input.

Ports:
clk  in  1  clock, rising-edge.
rst_n  in  1  asynchronous active-low reset.
en  in  1  clock enable; 0 freezes the block.
mode  in  1  0 = manual select, 1 = auto-scan.
s  in  SEL_W  manual channel select.
i  in  N_CH*DW  packed inputs; channel k = i[k*DW +: DW].
dwell  in  DWELL_W  in scan mode, each channel is held for dwell+1 enabled cycles.
y  out  DW  registered selected data.
ch  out  SEL_W  index of the channel whose data is in y.
valid  out  1  y holds legal channel data.
wrap  out  1  high while y holds the last dwell sample of channel N_CH-1 (scan mode only).
range_err  out  1  manual s >= N_CH.

Behaviour:
Reset (async, rst_n=0):
- y=0, ch=0, valid=0, wrap=0, range_err=0.
- Internal state: scan pointer p=0, dwell counter dc=0, mode_q=0.
- Reset mid-scan: all state clears immediately; the next enabled scan edge starts at channel 0.

Latency:
- One clock from input/select to y. There is no combinational path from i to y.
- ch, valid, wrap and range_err always update on the same edge as y.

State machine (two states, MAN and SCAN, taken from mode each enabled edge; mode_q records the previous state):
- MAN edge:
  - If s < N_CH: y<=i[s], ch<=s, valid<=1, range_err<=0.
  - Else: y<=0, ch<=s, valid<=0, range_err<=1.
  - wrap<=0. p and dc are held.
- SCAN edge:
  - Outputs: y<=i[p], ch<=p, valid<=1, range_err<=0.
  - If dc >= dwell (>= so that lowering dwell mid-dwell advances at once): dc<=0; p <= (p==N_CH-1) ? 0 : p+1; wrap <= (p==N_CH-1).
  - Else: dc<=dc+1, wrap<=0.
- SCAN entry (mode=1, mode_q=0): behaves as a normal scan edge with p and dc forced to 0 first. Every entry therefore starts at channel 0 with a fresh dwell.
- SCAN->MAN: the first MAN edge applies manual rules. p and dc are kept but are irrelevant, because re-entry resets them.

Other rules:
- dwell=0: the channel advances every enabled cycle and wrap pulses once per N_CH cycles.
- Full scan period: N_CH*(dwell+1) enabled cycles.
- en=0:
  - y, ch, p, dc and mode_q hold; range_err holds.
  - valid<=0, wrap<=0.
  - A mode change made while en=0 is detected on the next enabled edge.
- i may change at any time; only the value at the sampling edge matters.

Test Plan:
1. Reset, then en=1, mode=0, N_CH=8, DW=4, i=0x76543210, step s=0..7 -> one cycle after each s: y=s, ch=s, valid=1, wrap=0.
2. N_CH=6, manual s=7 -> y=0, valid=0, range_err=1. Then s=2 -> y=i[2], valid=1, range_err=0.
3. mode=1, dwell=2, N_CH=8 -> ch sequence 0,0,0,1,1,1,...,7,7,7,0. wrap=1 only on the third cycle of ch=7. Period = 24 cycles.
4. Scanning with dwell=0, drop en for 5 cycles at ch=3 -> y and ch frozen at 3, valid=0. After en=1 the scan resumes at ch=4 with valid=1.
5. Switch mode 1->0->1 mid-scan (ch=5) -> after re-entry the first scan output has ch=0, and the dwell count restarts.
6. Assert rst_n=0 asynchronously mid-scan (between edges) -> y=0, ch=0, valid=0, wrap=0 immediately. The first enabled scan edge after release gives ch=0.
